pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the 6502 core: per-byte source select (address bus or held PC),
//  +1 increment with full carry ripple across bytes, and the registered PC itself.
//  Replaces the per-byte combinational high/low selects; feeds the address mux and PCL/PCH-to-data-bus paths.
//  Adds page-cross and wrap flags consumed by the timing/control decoder.
// PARAMETERS
//  BYTE_W       8        width of one PC byte (one address-bus byte lane)
//  NUM_BYTES    2        PC bytes; PC width = BYTE_W*NUM_BYTES (2 -> 16-bit 6502 PC)
//  RESET_VALUE  16'hFFFC PC value after reset (width BYTE_W*NUM_BYTES; default targets the reset vector)
// PORTS
//  clk           in   1                    core clock; all state updates on rising edge
//  rst_n         in   1                    synchronous reset, active low
//  stall_IN      in   1                    1 = hold all state (RDY low)
//  load_EN       in   NUM_BYTES            per-byte: take byte from addrBus_IN instead of PC
//  addrBus_IN    in   BYTE_W*NUM_BYTES     address bus; byte i = bits [i*BYTE_W +: BYTE_W]
//  inc_EN        in   1                    add 1 to selected value this cycle
//  pc_OUT        out  BYTE_W*NUM_BYTES     registered program counter
//  pcSel_OUT     out  BYTE_W*NUM_BYTES     combinational selected value (pre-increment), to address mux
//  pageCross_OUT out  1                    registered: last update carried out of byte 0
//  wrap_OUT      out  1                    registered: last update carried out of top byte
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc_OUT=RESET_VALUE, pageCross_OUT=0, wrap_OUT=0. Reset beats stall_IN.
//  - sel[i] = load_EN[i] ? addrBus byte i : pc_OUT byte i. pcSel_OUT = sel, always driven (no latches; every
//    combinational path assigns a value in every branch).
//  - next = inc_EN ? sel + 1 : sel, computed at PC width +1; bit [PC_W] is wrap carry.
//  - Carry ripples across all bytes in the same cycle (no deferred PCH fix-up cycle inside this block).
//  - Latency: 1 cycle; pc_OUT shows next on the edge after the enables are sampled.
//  - Flags on each non-stalled edge: pageCross = inc_EN & (sel byte0 == all-ones);
//    wrap = inc_EN & (sel == all-ones). Without inc_EN both clear to 0. Flags are 1-cycle pulses.
//  - stall_IN=1 (rst_n=1): pc_OUT and flags hold; pcSel_OUT still tracks inputs.
//  - load_EN mixed (e.g. only byte 0): untouched bytes come from pc_OUT, then increment applies to whole value.
//  - load_EN all-zero and inc_EN=0: pc_OUT holds, flags clear.
//  - Reset mid-sequence (any enables active): reset wins; enables ignored that edge.
//  - NUM_BYTES=1 legal: pageCross_OUT == wrap_OUT.
// STRUCTURE
//  - Package pc_pkg: BYTE_W/NUM_BYTES defaults, PC_W localparam formula, RESET_VECTOR/NMI_VECTOR/IRQ_VECTOR
//    constants, typedef pc_t (logic [PC_W-1:0]).
//  - One sub-module pc_byte_sel (one BYTE_W mux: load_EN ? bus : pc), generated NUM_BYTES times.
//  - Top: generate loop, one adder, one always_ff for pc/flags.
// TESTING
//  1 rst_n=0 with load_EN=2'b11, addrBus=16'h1234 -> next edge pc=16'hFFFC, flags 0; pcSel_OUT=16'h1234.
//  2 pc=16'h80FF, inc_EN=1 -> pc=16'h8100, pageCross=1, wrap=0; next cycle inc_EN=0 -> flags 0.
//  3 pc=16'hFFFF, inc_EN=1 -> pc=16'h0000, pageCross=1, wrap=1.
//  4 pc=16'h1234, load_EN=2'b01, addrBus=16'hABFF, inc_EN=1 -> pc=16'h1300, pageCross=1.
//  5 pc=16'h2000, stall_IN=1, load_EN=2'b11, addrBus=16'h5555, inc_EN=1 for 3 cycles -> pc stays 16'h2000;
//    release stall -> pc=16'h5556.
//  6 Params NUM_BYTES=3, RESET_VALUE=24'h00FFFF: reset then inc_EN=1 -> pc=24'h010000, pageCross=1, wrap=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, vector addresses and PC type for the program-counter unit
package pc_pkg;
    localparam int BYTE_W_DEF    = 8;
    localparam int NUM_BYTES_DEF = 2;
    localparam int PC_W          = BYTE_W_DEF * NUM_BYTES_DEF;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;
    typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control, address-bus and PC/flag signals between the core and the PC unit
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int NUM_BYTES = NUM_BYTES_DEF
);
    logic                        stall_IN;
    logic [NUM_BYTES-1:0]        load_EN;
    logic [BYTE_W*NUM_BYTES-1:0] addrBus_IN;
    logic                        inc_EN;
    logic [BYTE_W*NUM_BYTES-1:0] pc_OUT;
    logic [BYTE_W*NUM_BYTES-1:0] pcSel_OUT;
    logic                        pageCross_OUT;
    logic                        wrap_OUT;
    modport master (
        output stall_IN, load_EN, addrBus_IN, inc_EN,
        input  pc_OUT, pcSel_OUT, pageCross_OUT, wrap_OUT
    );
    modport slave (
        input  stall_IN, load_EN, addrBus_IN, inc_EN,
        output pc_OUT, pcSel_OUT, pageCross_OUT, wrap_OUT
    );
endinterface

// File: rtl/pc_byte_sel.sv
// pc_byte_sel: one byte lane of the PC source select (address bus or held PC)
module pc_byte_sel
    import pc_pkg::*;
#(
    parameter int W = BYTE_W_DEF
) (
    input  logic         load_en,
    input  logic [W-1:0] bus_byte,
    input  logic [W-1:0] pc_byte,
    output logic [W-1:0] sel
);
    // Lane takes the bus byte when loading, otherwise keeps the current PC byte
    always_comb begin
        sel = load_en ? bus_byte : pc_byte;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with per-byte load, full-width increment and page/wrap flags
module pc_unit
    import pc_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter logic [BYTE_W*NUM_BYTES-1:0] RESET_VALUE = (BYTE_W*NUM_BYTES)'(RESET_VECTOR)
) (
    input logic        clk,
    input logic        rst_n,
    pc_unit_if.slave   bus
);
    localparam int PW = BYTE_W * NUM_BYTES;

    logic [PW-1:0] pc_q, pc_d, sel;
    logic [PW:0]   sum;
    logic          page_cross_q, page_cross_d;
    logic          wrap_q, wrap_d;

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        pc_byte_sel #(.W(BYTE_W)) u_sel (
            .load_en  (bus.load_EN[g]),
            .bus_byte (bus.addrBus_IN[g*BYTE_W +: BYTE_W]),
            .pc_byte  (pc_q[g*BYTE_W +: BYTE_W]),
            .sel      (sel[g*BYTE_W +: BYTE_W])
        );
    end

    // Single adder one bit wider than the PC so the carry ripples through every byte this cycle
    always_comb begin
        sum          = {1'b0, sel} + (PW+1)'(bus.inc_EN);
        pc_d         = !rst_n ? RESET_VALUE : bus.stall_IN ? pc_q : sum[PW-1:0];
        page_cross_d = !rst_n ? 1'b0 : bus.stall_IN ? page_cross_q : bus.inc_EN & (&sel[BYTE_W-1:0]);
        wrap_d       = !rst_n ? 1'b0 : bus.stall_IN ? wrap_q : sum[PW];
    end

    // PC and flag registers; reset and stall are already folded into the next values
    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        page_cross_q <= page_cross_d;
        wrap_q       <= wrap_d;
    end

    assign bus.pc_OUT        = pc_q;
    assign bus.pcSel_OUT     = sel;
    assign bus.pageCross_OUT = page_cross_q;
    assign bus.wrap_OUT      = wrap_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit in the 16-bit default and a 24-bit configuration
module tb_pc_unit;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.BYTE_W(8), .NUM_BYTES(2)) b2 ();
    pc_unit_if #(.BYTE_W(8), .NUM_BYTES(3)) b3 ();

    pc_unit #(.BYTE_W(8), .NUM_BYTES(2), .RESET_VALUE(16'hFFFC)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    pc_unit #(.BYTE_W(8), .NUM_BYTES(3), .RESET_VALUE(24'h00FFFF)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic st, input logic [1:0] ld, input logic [15:0] ab, input logic inc);
        b2.stall_IN   = st;
        b2.load_EN    = ld;
        b2.addrBus_IN = ab;
        b2.inc_EN     = inc;
    endtask

    task automatic chk2(input string tag, input logic [15:0] pc, input logic pg, input logic wr);
        chk({tag, "_pc"}, 32'(b2.pc_OUT), 32'(pc));
        chk({tag, "_pg"}, 32'(b2.pageCross_OUT), 32'(pg));
        chk({tag, "_wr"}, 32'(b2.wrap_OUT), 32'(wr));
    endtask

    initial begin
        rst_n = 1'b0;
        drive2(1'b0, 2'b11, 16'h1234, 1'b0);
        b3.stall_IN   = 1'b0;
        b3.load_EN    = 3'b000;
        b3.addrBus_IN = 24'h0;
        b3.inc_EN     = 1'b0;
        #1;
        chk("rst_sel", 32'(b2.pcSel_OUT), 32'h1234);
        step();
        chk2("rst", 16'hFFFC, 1'b0, 1'b0);
        chk("rst3_pc", 32'(b3.pc_OUT), 32'h00FFFF);

        rst_n = 1'b1;
        drive2(1'b0, 2'b11, 16'h80FF, 1'b0);
        b3.inc_EN = 1'b1;
        step();
        chk2("ld80ff", 16'h80FF, 1'b0, 1'b0);
        chk("p3_pc", 32'(b3.pc_OUT), 32'h010000);
        chk("p3_pg", 32'(b3.pageCross_OUT), 32'h1);
        chk("p3_wr", 32'(b3.wrap_OUT), 32'h0);
        b3.inc_EN = 1'b0;

        drive2(1'b0, 2'b00, 16'h0000, 1'b1);
        step();
        chk2("inc80ff", 16'h8100, 1'b1, 1'b0);
        drive2(1'b0, 2'b00, 16'h0000, 1'b0);
        step();
        chk2("idle", 16'h8100, 1'b0, 1'b0);

        drive2(1'b0, 2'b11, 16'hFFFF, 1'b0);
        step();
        chk2("ldffff", 16'hFFFF, 1'b0, 1'b0);
        drive2(1'b0, 2'b00, 16'h0000, 1'b1);
        step();
        chk2("wrap", 16'h0000, 1'b1, 1'b1);

        drive2(1'b0, 2'b11, 16'h1234, 1'b0);
        step();
        chk2("ld1234", 16'h1234, 1'b0, 1'b0);
        drive2(1'b0, 2'b01, 16'hABFF, 1'b1);
        #1;
        chk("mix_sel", 32'(b2.pcSel_OUT), 32'h12FF);
        step();
        chk2("mix", 16'h1300, 1'b1, 1'b0);

        drive2(1'b1, 2'b11, 16'h7777, 1'b1);
        step();
        chk2("stall_flag", 16'h1300, 1'b1, 1'b0);

        drive2(1'b0, 2'b11, 16'h2000, 1'b0);
        step();
        chk2("ld2000", 16'h2000, 1'b0, 1'b0);
        drive2(1'b1, 2'b11, 16'h5555, 1'b1);
        #1;
        chk("stall_sel", 32'(b2.pcSel_OUT), 32'h5555);
        for (int i = 0; i < 3; i++) begin
            step();
            chk2("stall", 16'h2000, 1'b0, 1'b0);
        end
        b2.stall_IN = 1'b0;
        step();
        chk2("release", 16'h5556, 1'b0, 1'b0);

        rst_n = 1'b0;
        drive2(1'b1, 2'b11, 16'h4321, 1'b1);
        step();
        chk2("rst_mid", 16'hFFFC, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
